// File: rtl/irrigacao_atuador.sv
// Irrigation valve sequencer: serves one area at a time for a fixed on-time,
// then rests; round-robin between areas on a tie, with a 7-segment area digit.
module irrigacao_atuador #(
  parameter int ON_CYCLES   = 8,
  parameter int REST_CYCLES = 4,
  parameter int CW          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] S,
  output logic [1:0] valve,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] o_dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WATER0 = 2'd1;
  localparam logic [1:0] ST_WATER1 = 2'd2;
  localparam logic [1:0] ST_REST   = 2'd3;

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] REST_LAST = CW'(REST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [6:0] SEG_DIGIT0 = 7'b1111110;
  localparam logic [6:0] SEG_DIGIT1 = 7'b0110000;
  localparam logic [6:0] SEG_BLANK  = 7'b0000000;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_last;
  logic          w_last_nxt;

  logic [1:0]    r_valve;
  logic          r_busy;
  logic          r_done;
  logic [6:0]    r_seg;
  logic [1:0]    w_valve_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [6:0]    w_seg_nxt;

  // Requests are only looked at in IDLE; the counter is shared by WATER and REST.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        case (S)
          2'b01: begin
            w_state_nxt = ST_WATER0;
            w_last_nxt  = 1'b0;
          end
          2'b10: begin
            w_state_nxt = ST_WATER1;
            w_last_nxt  = 1'b1;
          end
          2'b11: begin
            if (r_last) begin
              w_state_nxt = ST_WATER0;
              w_last_nxt  = 1'b0;
            end else begin
              w_state_nxt = ST_WATER1;
              w_last_nxt  = 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
      ST_WATER0, ST_WATER1: begin
        if (r_cnt == ON_LAST) begin
          w_state_nxt = ST_REST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_REST: begin
        if (r_cnt == REST_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_comb begin
    w_valve_nxt = 2'b00;
    w_seg_nxt   = SEG_BLANK;
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_REST) && (r_state != ST_REST);
    case (w_state_nxt)
      ST_WATER0: begin
        w_valve_nxt = 2'b01;
        w_seg_nxt   = SEG_DIGIT0;
      end
      ST_WATER1: begin
        w_valve_nxt = 2'b10;
        w_seg_nxt   = SEG_DIGIT1;
      end
      default: begin
        w_valve_nxt = 2'b00;
        w_seg_nxt   = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_valve <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_seg   <= SEG_BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_valve <= w_valve_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign valve       = r_valve;
  assign busy        = r_busy;
  assign done        = r_done;
  assign seg         = r_seg;
  assign o_dbg_state = r_state;

endmodule
